// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR note engine: speed encoding, per-tick step lookup and
// an index-width helper that never returns zero.
package ddr_pkg;

    typedef enum logic [1:0] {
        SpeedSlow      = 2'b00,
        SpeedNormal    = 2'b01,
        SpeedFast      = 2'b10,
        SpeedNormalAlt = 2'b11
    } speed_e;

    localparam int unsigned StepW = 3;

    function automatic logic [StepW-1:0] step_px(input logic [1:0] speed);
        logic [StepW-1:0] px;
        unique case (speed_e'(speed))
            SpeedSlow:      px = 3'd1;
            SpeedNormal:    px = 3'd2;
            SpeedFast:      px = 3'd4;
            SpeedNormalAlt: px = 3'd2;
            default:        px = 3'd2;
        endcase
        return px;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_lane.sv
// One lane of falling notes: slot storage, free/hit priority selection, advance and miss
// detection, and rising-edge detection of the lane button.
module ddr_lane
    import ddr_pkg::*;
#(
    parameter int unsigned SLOTS  = 8,
    parameter int unsigned YW     = 9,
    parameter int unsigned HIT_Y  = 400,
    parameter int unsigned WINDOW = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic [1:0]        speed_i,
    input  logic              spawn_i,
    input  logic              press_i,
    output logic              free_o,
    output logic              hit_o,
    output logic              miss_o,
    output logic [SLOTS-1:0]    slot_valid_o,
    output logic [SLOTS*YW-1:0] slot_y_o
);

    localparam int unsigned    YLo  = (HIT_Y > WINDOW) ? HIT_Y - WINDOW : 0;
    localparam logic [YW-1:0]  YLoV = YW'(YLo);
    localparam logic [YW:0]    YHiV = (YW+1)'(HIT_Y + WINDOW);

    logic [SLOTS-1:0] valid_q, valid_d;
    logic [YW-1:0]    y_q [SLOTS];
    logic [YW-1:0]    y_d [SLOTS];
    logic             press_q;
    logic             press_rise;
    logic [SLOTS-1:0] hit_sel, free_sel;
    logic             found_hit, found_free;
    logic [YW:0]      sum;

    function automatic logic in_window(input logic [YW-1:0] y);
        return (y >= YLoV) && ({1'b0, y} <= YHiV);
    endfunction

    // Lowest-index selection for both the judged slot and the spawn target.
    always_comb begin
        press_rise = press_i & ~press_q;
        hit_sel    = '0;
        free_sel   = '0;
        found_hit  = 1'b0;
        found_free = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!found_hit && press_rise && valid_q[i] && in_window(y_q[i])) begin
                hit_sel[i] = 1'b1;
                found_hit  = 1'b1;
            end
            if (!found_free && !valid_q[i]) begin
                free_sel[i] = 1'b1;
                found_free  = 1'b1;
            end
        end
    end

    // Judging sees pre-advance y, so a hit slot is cleared before it could be missed.
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        miss_o  = 1'b0;
        sum     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (valid_q[i]) begin
                if (hit_sel[i]) begin
                    valid_d[i] = 1'b0;
                end else if (tick_i) begin
                    sum = {1'b0, y_q[i]} + (YW+1)'(step_px(speed_i));
                    if (sum > YHiV) begin
                        valid_d[i] = 1'b0;
                        miss_o     = 1'b1;
                    end else begin
                        y_d[i] = sum[YW-1:0];
                    end
                end
            end else if (spawn_i && free_sel[i]) begin
                valid_d[i] = 1'b1;
                y_d[i]     = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            press_q <= 1'b1;
            for (int i = 0; i < SLOTS; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            press_q <= press_i;
            for (int i = 0; i < SLOTS; i++) begin
                y_q[i] <= y_d[i];
            end
        end
    end

    always_comb begin
        slot_y_o = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_y_o[i*YW +: YW] = y_q[i];
        end
    end

    assign free_o       = found_free;
    assign hit_o        = found_hit;
    assign slot_valid_o = valid_q;

endmodule

// File: rtl/ddr_lane_judge.sv
// DDR note engine top: per-lane note storage, spawn routing, score/combo accumulation and
// a registered read port for the renderer.
module ddr_lane_judge
    import ddr_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned SLOTS       = 8,
    parameter int unsigned YW          = 9,
    parameter int unsigned HIT_Y       = 400,
    parameter int unsigned WINDOW      = 16,
    parameter int unsigned SCORE_W     = 15,
    parameter int unsigned COMBO_BONUS = 8
) (
    input  logic                      dclk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [1:0]                speed,
    input  logic                      spawn_valid,
    input  logic [idx_w(LANES)-1:0]   spawn_lane,
    output logic                      spawn_ready,
    input  logic [LANES-1:0]          press,
    input  logic [idx_w(LANES)-1:0]   rd_lane,
    input  logic [idx_w(SLOTS)-1:0]   rd_slot,
    output logic                      rd_valid,
    output logic [YW-1:0]             rd_y,
    output logic [LANES-1:0]          hit_pulse,
    output logic [LANES-1:0]          miss_pulse,
    output logic [SCORE_W-1:0]        score,
    output logic [SCORE_W-1:0]        combo
);

    localparam int unsigned LW = idx_w(LANES);
    localparam int unsigned SW = idx_w(SLOTS);
    localparam int unsigned CW = LW + 1;
    localparam int unsigned AW = SCORE_W + CW + 1;
    localparam logic [SCORE_W-1:0] ScoreMax = '1;

    logic [LANES-1:0]          lane_free, lane_hit, lane_miss, spawn_en;
    logic [LANES*SLOTS-1:0]    all_valid;
    logic [LANES*SLOTS*YW-1:0] all_y;

    logic [CW-1:0]      n_hits;
    logic [CW:0]        inc;
    logic [AW-1:0]      score_sum, combo_sum;
    logic [SCORE_W-1:0] score_q, score_d, combo_q, combo_d;
    logic [LANES-1:0]   hit_q, miss_q;
    logic               rd_valid_q, rd_valid_d;
    logic [YW-1:0]      rd_y_q, rd_y_d;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ddr_lane #(
            .SLOTS  (SLOTS),
            .YW     (YW),
            .HIT_Y  (HIT_Y),
            .WINDOW (WINDOW)
        ) u_lane (
            .clk_i        (dclk),
            .rst_i        (reset),
            .tick_i       (tick),
            .speed_i      (speed),
            .spawn_i      (spawn_en[l]),
            .press_i      (press[l]),
            .free_o       (lane_free[l]),
            .hit_o        (lane_hit[l]),
            .miss_o       (lane_miss[l]),
            .slot_valid_o (all_valid[l*SLOTS +: SLOTS]),
            .slot_y_o     (all_y[l*SLOTS*YW +: SLOTS*YW])
        );
    end

    always_comb begin
        spawn_ready = 1'b0;
        spawn_en    = '0;
        for (int l = 0; l < LANES; l++) begin
            if (spawn_lane == LW'(l)) begin
                spawn_ready = lane_free[l];
                spawn_en[l] = spawn_valid & lane_free[l];
            end
        end
    end

    // Bonus is decided on the combo value held at the start of the cycle.
    always_comb begin
        n_hits = '0;
        for (int l = 0; l < LANES; l++) begin
            n_hits = n_hits + CW'(lane_hit[l]);
        end
        inc       = (combo_q >= SCORE_W'(COMBO_BONUS)) ? {n_hits, 1'b0} : {1'b0, n_hits};
        score_sum = AW'(score_q) + AW'(inc);
        combo_sum = AW'(combo_q) + AW'(n_hits);
        score_d   = (score_sum > AW'(ScoreMax)) ? ScoreMax : score_sum[SCORE_W-1:0];
        if (|lane_miss) begin
            combo_d = '0;
        end else begin
            combo_d = (combo_sum > AW'(ScoreMax)) ? ScoreMax : combo_sum[SCORE_W-1:0];
        end
    end

    always_comb begin
        rd_valid_d = 1'b0;
        rd_y_d     = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (rd_lane == LW'(l) && rd_slot == SW'(s)) begin
                    rd_valid_d = all_valid[l*SLOTS + s];
                    rd_y_d     = all_y[(l*SLOTS + s)*YW +: YW];
                end
            end
        end
    end

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            score_q    <= '0;
            combo_q    <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_y_q     <= '0;
        end else begin
            score_q    <= score_d;
            combo_q    <= combo_d;
            hit_q      <= lane_hit;
            miss_q     <= lane_miss;
            rd_valid_q <= rd_valid_d;
            rd_y_q     <= rd_y_d;
        end
    end

    assign score      = score_q;
    assign combo      = combo_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign rd_valid   = rd_valid_q;
    assign rd_y       = rd_y_q;

endmodule

// File: tb/tb_ddr_lane_judge.sv
// Directed bench for ddr_lane_judge: per-cycle expectations are queued when stimulus is
// driven and compared one cycle later against the DUT's registered outputs.
module tb_ddr_lane_judge;

    logic        dclk = 1'b0;
    logic        reset;
    logic        tick;
    logic [1:0]  speed;
    logic        spawn_valid;
    logic [1:0]  spawn_lane;
    logic        spawn_ready;
    logic [3:0]  press;
    logic [1:0]  rd_lane;
    logic [2:0]  rd_slot;
    logic        rd_valid;
    logic [8:0]  rd_y;
    logic [3:0]  hit_pulse;
    logic [3:0]  miss_pulse;
    logic [14:0] score;
    logic [14:0] combo;

    int errors = 0;
    int checks = 0;
    int m_score = 0;
    int m_combo = 0;

    typedef struct {
        string      tag;
        logic [3:0] hit;
        logic [3:0] miss;
        int         score;
        int         combo;
    } exp_t;

    exp_t sbq[$];

    ddr_lane_judge dut (
        .dclk        (dclk),
        .reset       (reset),
        .tick        (tick),
        .speed       (speed),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_ready (spawn_ready),
        .press       (press),
        .rd_lane     (rd_lane),
        .rd_slot     (rd_slot),
        .rd_valid    (rd_valid),
        .rd_y        (rd_y),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .score       (score),
        .combo       (combo)
    );

    always #5 dclk = ~dclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Queue the expected outcome of this cycle, clock it, then compare.
    task automatic step(input string tag, input logic [3:0] eh, input logic [3:0] em);
        exp_t e;
        int   n;
        int   inc;
        n   = $countones(eh);
        inc = (m_combo >= 8) ? 2 * n : n;
        m_score = (m_score + inc > 32767) ? 32767 : m_score + inc;
        if (em != 4'd0) m_combo = 0;
        else m_combo = (m_combo + n > 32767) ? 32767 : m_combo + n;
        e.tag = tag; e.hit = eh; e.miss = em; e.score = m_score; e.combo = m_combo;
        sbq.push_back(e);
        @(posedge dclk);
        #1;
        e = sbq.pop_front();
        chk({e.tag, "/hit"}, 32'(hit_pulse), 32'(e.hit));
        chk({e.tag, "/miss"}, 32'(miss_pulse), 32'(e.miss));
        chk({e.tag, "/score"}, 32'(score), e.score);
        chk({e.tag, "/combo"}, 32'(combo), e.combo);
    endtask

    task automatic ticks(input int n, input string tag);
        tick = 1'b1;
        for (int i = 0; i < n; i++) step(tag, 4'd0, 4'd0);
        tick = 1'b0;
    endtask

    task automatic spawn(input logic [1:0] lane);
        spawn_lane  = lane;
        spawn_valid = 1'b1;
        step("spawn", 4'd0, 4'd0);
        spawn_valid = 1'b0;
    endtask

    task automatic hit_lane(input logic [3:0] mask, input string tag);
        press = mask;
        step(tag, mask, 4'd0);
        press = 4'd0;
        step({tag, "_rel"}, 4'd0, 4'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "/hit"}, 32'(hit_pulse), 0);
        chk({tag, "/miss"}, 32'(miss_pulse), 0);
        chk({tag, "/score"}, 32'(score), 0);
        chk({tag, "/combo"}, 32'(combo), 0);
        chk({tag, "/rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "/rd_y"}, 32'(rd_y), 0);
        for (int l = 0; l < 4; l++) begin
            spawn_lane = 2'(l);
            #1;
            chk({tag, "/ready"}, 32'(spawn_ready), 1);
        end
        @(posedge dclk);
        #1;
        reset   = 1'b0;
        m_score = 0;
        m_combo = 0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; speed = 2'b10; spawn_valid = 1'b0; spawn_lane = 2'd0;
        press = 4'd0; rd_lane = 2'd0; rd_slot = 3'd0;
        repeat (2) @(posedge dclk);
        #1;
        do_reset("por");

        // Single hit at y=400 in lane 2, plus read-port latency.
        rd_lane = 2'd2;
        rd_slot = 3'd0;
        spawn(2'd2);
        ticks(100, "adv2");
        press = 4'b0100;
        step("hit2", 4'b0100, 4'd0);
        chk("hit2/rd_valid", 32'(rd_valid), 1);
        chk("hit2/rd_y", 32'(rd_y), 400);
        press = 4'd0;
        step("hit2_rel", 4'd0, 4'd0);
        chk("hit2/rd_cleared", 32'(rd_valid), 0);

        // Reset mid-play with live notes.
        rd_lane = 2'd0;
        spawn(2'd0);
        spawn(2'd3);
        ticks(5, "live");
        chk("live/rd_valid", 32'(rd_valid), 1);
        chk("live/rd_y", 32'(rd_y), 16);
        do_reset("midrst");
        step("post_rst", 4'd0, 4'd0);
        chk("post_rst/rd_valid", 32'(rd_valid), 0);

        // Early press does nothing; a later hit builds combo; a note past 416 misses.
        spawn(2'd1);
        spawn(2'd0);
        ticks(75, "adv3a");
        press = 4'b0010;
        step("early", 4'd0, 4'd0);
        press = 4'd0;
        step("early_rel", 4'd0, 4'd0);
        ticks(25, "adv3b");
        hit_lane(4'b0001, "hit0");
        ticks(4, "edge416");
        tick = 1'b1;
        step("miss1", 4'd0, 4'b0010);
        tick = 1'b0;

        // Lane-full back-pressure, then consecutive hits with the combo bonus.
        do_reset("rst4");
        for (int i = 0; i < 8; i++) begin
            spawn_lane = 2'd0;
            #1;
            chk("fill/ready", 32'(spawn_ready), 1);
            spawn(2'd0);
        end
        spawn_lane = 2'd0;
        #1;
        chk("full/ready", 32'(spawn_ready), 0);
        spawn(2'd0);
        spawn_lane = 2'd1;
        #1;
        chk("other/ready", 32'(spawn_ready), 1);
        spawn(2'd1);
        spawn(2'd2);
        spawn(2'd3);
        ticks(100, "adv5");
        for (int i = 0; i < 8; i++) hit_lane(4'b0001, "chain");
        chk("chain/score8", 32'(score), 8);
        press = 4'b0001;
        step("dropped", 4'd0, 4'd0);
        press = 4'd0;
        step("dropped_rel", 4'd0, 4'd0);
        hit_lane(4'b0010, "bonus");
        chk("bonus/score10", 32'(score), 10);
        hit_lane(4'b1100, "dual");

        // Hit in lane 1 and miss in lane 0 in the same tick cycle.
        spawn(2'd0);
        ticks(1, "lead");
        spawn(2'd1);
        ticks(103, "adv5b");
        tick  = 1'b1;
        press = 4'b0010;
        step("hitmiss", 4'b0010, 4'b0001);
        tick  = 1'b0;
        press = 4'd0;
        step("hitmiss_rel", 4'd0, 4'd0);

        // Button held through reset release must not register until re-pressed.
        press = 4'b1000;
        do_reset("rst6");
        spawn(2'd3);
        ticks(100, "held");
        press = 4'd0;
        step("held_rel", 4'd0, 4'd0);
        hit_lane(4'b1000, "repress");

        // Tick and press together at y = HIT_Y + WINDOW.
        spawn(2'd2);
        ticks(104, "adv416");
        tick  = 1'b1;
        press = 4'b0100;
        step("edge_hit", 4'b0100, 4'd0);
        press = 4'd0;
        step("edge_nomiss", 4'd0, 4'd0);
        tick  = 1'b0;

        // Step sizes for each speed code.
        rd_lane = 2'd0;
        rd_slot = 3'd0;
        spawn(2'd0);
        speed = 2'b00;
        ticks(3, "slow");
        speed = 2'b11;
        ticks(1, "alt");
        speed = 2'b01;
        ticks(1, "normal");
        step("idle", 4'd0, 4'd0);
        chk("speed/rd_valid", 32'(rd_valid), 1);
        chk("speed/rd_y", 32'(rd_y), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
